// File: rtl/serial_strobe_tx.sv
// -----------------------------------------------------------------------------
// serial_strobe_tx
//
// Bit-serial transmitter feeding an enable-gated capture flop. A parallel word
// is accepted over a valid/ready handshake. Each bit is then held on d for DIV
// clocks. A single-cycle enable strobe is placed mid-bit, so the receiving
// flop samples a settled value. frame brackets the bits of a word. done
// pulses for one cycle once the last bit period has ended.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   data_in    in   [WIDTH] parallel word to send
//   valid_in   in   data_in valid
//   ready_out  out  block can accept a word this cycle
//   d          out  serial data bit
//   enable     out  one-cycle sample strobe for the receiver, mid-bit
//   frame      out  high while bits of a word are on d
//   done       out  one-cycle pulse after the last bit period ends
//
// All outputs come straight from flops. The next-state logic also computes
// the value each output will have in the coming cycle. That value is then
// registered alongside the state.
// -----------------------------------------------------------------------------
module serial_strobe_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d,
  output logic             enable,
  output logic             frame,
  output logic             done
);

  localparam int DW = $clog2(DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg,  state_next;
  logic [DW-1:0]    div_reg,    div_next;
  logic [BW-1:0]    bit_reg,    bit_next;
  logic [WIDTH-1:0] shift_reg,  shift_next;

  logic             ready_reg,  ready_next;
  logic             d_reg,      d_next;
  logic             enable_reg, enable_next;
  logic             frame_reg,  frame_next;
  logic             done_reg,   done_next;

  logic             accept;
  logic [WIDTH-1:0] load_word;

  // Put the first bit to transmit in the MSB of the shift register. The
  // shifter then always moves left, whichever bit order is chosen.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign load_word[gi] = data_in[gi];
      end else begin : g_lsb
        assign load_word[gi] = data_in[WIDTH-1-gi];
      end
    end
  endgenerate

  // The handshake uses the registered ready. Valid is therefore ignored in
  // every cycle where ready_out reads low. This includes the first cycle
  // after reset.
  assign accept = valid_in & ready_reg;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      div_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      ready_reg  <= 1'b0;
      d_reg      <= 1'b0;
      enable_reg <= 1'b0;
      frame_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      ready_reg  <= ready_next;
      d_reg      <= d_next;
      enable_reg <= enable_next;
      frame_reg  <= frame_next;
      done_reg   <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next = load_word;
          div_next   = '0;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (bit_reg == BIT_LAST) begin
            state_next = DONE;
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg << 1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      DONE: begin
        // ready is high here, so a waiting word starts with no idle gap.
        if (accept) begin
          shift_next = load_word;
          div_next   = '0;
          bit_next   = '0;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output values for the coming cycle. These are derived from the next
  // state, so the registered outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_next  = (state_next == SHIFT);
    enable_next = frame_next && (div_next == DIV_HALF);
    d_next      = frame_next & shift_next[WIDTH-1];
    done_next   = (state_next == DONE);
    ready_next  = (state_next != SHIFT);
  end

  assign ready_out = ready_reg;
  assign d         = d_reg;
  assign enable    = enable_reg;
  assign frame     = frame_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_serial_strobe_tx.sv
// -----------------------------------------------------------------------------
// Directed bench for serial_strobe_tx. Instance a sends MSB first and
// instance b sends LSB first; both use WIDTH=8 and DIV=4. Outputs are sampled
// on the falling edge. Inputs are changed on the falling edge too.
// -----------------------------------------------------------------------------
module tb_serial_strobe_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] data_in_a  = 8'h00;
  logic       valid_in_a = 1'b0;
  logic       ready_out_a, d_a, enable_a, frame_a, done_a;

  logic [7:0] data_in_b  = 8'h00;
  logic       valid_in_b = 1'b0;
  logic       ready_out_b, d_b, enable_b, frame_b, done_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  serial_strobe_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in_a),
    .valid_in  (valid_in_a),
    .ready_out (ready_out_a),
    .d         (d_a),
    .enable    (enable_a),
    .frame     (frame_a),
    .done      (done_a)
  );

  serial_strobe_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in_b),
    .valid_in  (valid_in_b),
    .ready_out (ready_out_b),
    .d         (d_b),
    .enable    (enable_b),
    .frame     (frame_b),
    .done      (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hands a word to instance a (inst=0) or b (inst=1) at the current falling
  // edge. It then records the 32 cycles after the accepting edge, one trace
  // bit per cycle with the first cycle in bit 31. It returns at the falling
  // edge of the cycle where done should be high. rx models the receiving
  // enable-gated flop: it shifts d in on every strobe.
  task automatic run_word(input bit inst, input logic [7:0] word,
                          input bit wiggle, input bit keep_valid,
                          output logic [31:0] dtr, output logic [31:0] entr,
                          output logic [31:0] frtr, output logic [31:0] rdtr,
                          output logic [31:0] dntr, output logic [7:0] rx);
    logic od, oe, of, orr, odn;
    dtr = '0; entr = '0; frtr = '0; rdtr = '0; dntr = '0; rx = '0;
    if (inst) begin
      data_in_b = word; valid_in_b = 1'b1;
    end else begin
      data_in_a = word; valid_in_a = 1'b1;
    end
    @(negedge clock);
    if (!keep_valid) begin
      if (inst) valid_in_b = 1'b0;
      else      valid_in_a = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      od  = inst ? d_b         : d_a;
      oe  = inst ? enable_b    : enable_a;
      of  = inst ? frame_b     : frame_a;
      orr = inst ? ready_out_b : ready_out_a;
      odn = inst ? done_b      : done_a;
      dtr[31-i]  = od;
      entr[31-i] = oe;
      frtr[31-i] = of;
      rdtr[31-i] = orr;
      dntr[31-i] = odn;
      if (oe) rx = inst ? {od, rx[7:1]} : {rx[6:0], od};
      if (wiggle) begin
        data_in_a  = 8'($urandom);
        valid_in_a = (i < 30) && i[0];
      end
      @(negedge clock);
    end
  endtask

  task automatic check_done_cycle(input bit inst, input string tag);
    check({tag, " done"},  inst ? done_b      : done_a,      1'b1);
    check({tag, " frame"}, inst ? frame_b     : frame_a,     1'b0);
    check({tag, " en"},    inst ? enable_b    : enable_a,    1'b0);
    check({tag, " d"},     inst ? d_b         : d_a,         1'b0);
    check({tag, " ready"}, inst ? ready_out_b : ready_out_a, 1'b1);
  endtask

  task automatic check_traces(input string tag, input logic [31:0] dtr,
                              input logic [31:0] entr, input logic [31:0] frtr,
                              input logic [31:0] rdtr, input logic [31:0] dntr,
                              input logic [7:0] rx, input logic [31:0] exp_d,
                              input logic [7:0] exp_rx);
    check({tag, " d trace"},     dtr,  exp_d);
    check({tag, " en trace"},    entr, 32'h2222_2222);
    check({tag, " frame trace"}, frtr, 32'hFFFF_FFFF);
    check({tag, " ready trace"}, rdtr, 32'h0000_0000);
    check({tag, " done trace"},  dntr, 32'h0000_0000);
    check({tag, " strobes"},     32'($countones(entr)), 32'd8);
    check({tag, " rx"},          rx,   exp_rx);
  endtask

  logic [31:0] dtr, entr, frtr, rdtr, dntr;
  logic [7:0]  rx;
  int          strobes, stray_en, stray_done, stray_frame;

  initial begin
    // 1: reset held for three cycles, then released
    @(posedge clock);
    @(negedge clock);
    check("rst d",     d_a,         1'b0);
    check("rst en",    enable_a,    1'b0);
    check("rst frame", frame_a,     1'b0);
    check("rst done",  done_a,      1'b0);
    check("rst ready", ready_out_a, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst ready a", ready_out_a, 1'b1);
    check("post-rst ready b", ready_out_b, 1'b1);
    check("post-rst frame",   frame_a,     1'b0);

    // 2: 0xA5 MSB first. Bits 1,0,1,0,0,1,0,1, each held four cycles.
    run_word(1'b0, 8'hA5, 1'b0, 1'b0, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("a5", dtr, entr, frtr, rdtr, dntr, rx, 32'hF0F0_0F0F, 8'hA5);
    check_done_cycle(1'b0, "a5");
    @(negedge clock);
    check("a5 idle frame", frame_a, 1'b0);
    check("a5 idle done",  done_a,  1'b0);

    // 3: 0x01 LSB first. d is high for the first bit only.
    run_word(1'b1, 8'h01, 1'b0, 1'b0, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("lsb01", dtr, entr, frtr, rdtr, dntr, rx, 32'hF000_0000, 8'h01);
    check_done_cycle(1'b1, "lsb01");
    @(negedge clock);

    // 4: back-to-back. valid stays high; 0xC3 is presented in the done cycle.
    run_word(1'b0, 8'h3C, 1'b0, 1'b1, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("b2b 3c", dtr, entr, frtr, rdtr, dntr, rx, 32'h00FF_FF00, 8'h3C);
    check_done_cycle(1'b0, "b2b 3c");
    strobes = $countones(entr);
    run_word(1'b0, 8'hC3, 1'b0, 1'b0, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("b2b c3", dtr, entr, frtr, rdtr, dntr, rx, 32'hFF00_00FF, 8'hC3);
    check_done_cycle(1'b0, "b2b c3");
    strobes += $countones(entr);
    check("b2b strobes", 32'(strobes), 32'd16);
    @(negedge clock);
    check("b2b no extra accept", frame_a, 1'b0);

    // 5: data_in and valid_in wiggle during SHIFT. The word in flight must
    // be unchanged.
    run_word(1'b0, 8'h96, 1'b1, 1'b0, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("wiggle", dtr, entr, frtr, rdtr, dntr, rx, 32'hF00F_0FF0, 8'h96);
    check_done_cycle(1'b0, "wiggle");
    valid_in_a = 1'b0;
    @(negedge clock);
    check("wiggle idle frame", frame_a, 1'b0);

    // 6: reset lands in the first cycle of bit 3 of 0xFF.
    data_in_a = 8'hFF; valid_in_a = 1'b1;
    @(negedge clock);
    valid_in_a = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clock);
    check("ff bit3 frame", frame_a, 1'b1);
    check("ff bit3 d",     d_a,     1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst d",     d_a,      1'b0);
    check("midrst frame", frame_a,  1'b0);
    check("midrst en",    enable_a, 1'b0);
    check("midrst done",  done_a,   1'b0);
    reset = 1'b0;
    stray_en = 0; stray_done = 0; stray_frame = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (enable_a) stray_en++;
      if (done_a)   stray_done++;
      if (frame_a)  stray_frame++;
    end
    check("midrst stray strobes", 32'(stray_en),    32'd0);
    check("midrst stray done",    32'(stray_done),  32'd0);
    check("midrst stray frame",   32'(stray_frame), 32'd0);
    check("midrst ready",         ready_out_a,      1'b1);
    run_word(1'b0, 8'h5A, 1'b0, 1'b0, dtr, entr, frtr, rdtr, dntr, rx);
    check_traces("after rst 5a", dtr, entr, frtr, rdtr, dntr, rx, 32'h0F0F_F0F0, 8'h5A);
    check_done_cycle(1'b0, "after rst 5a");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_strobe_tx.md
Name: serial_strobe_tx

Overview:
Bit-serial transmitter that drives the d/enable pair consumed by the team's enable-gated capture flop (dff). It accepts a parallel word through a valid/ready handshake. It then shifts the word out on d, one bit per DIV clocks, with a one-cycle enable strobe placed mid-bit so that a downstream enable-qualified flop samples a stable bit. A frame flag and a done pulse bracket each word for link-level sequencing and bench checkers.

Parameters:
WIDTH, 8, bits per word (>=1)
DIV, 4, clock cycles per serial bit (>=2)
MSB_FIRST, 1, 1 = send data_in[WIDTH-1] first; 0 = send data_in[0] first

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to send
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word this cycle
d  output  1  serial data bit
enable  output  1  one-cycle sample strobe for the receiver, mid-bit
frame  output  1  high while bits of a word are on d
done  output  1  one-cycle pulse after the last bit period ends

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values (cycle after reset is sampled high): d=0, enable=0, frame=0, done=0, ready_out=0. ready_out rises in the first cycle after reset deasserts. State=IDLE, all counters=0.
- FSM states:
  - IDLE: ready_out=1, d=0, frame=0. On an edge with valid_in&ready_out, load the shift register from data_in, clear bit_cnt and div_cnt, go to SHIFT.
  - SHIFT: ready_out=0, frame=1. d holds the current bit for exactly DIV cycles. div_cnt counts 0..DIV-1.
    - enable=1 in the single cycle where div_cnt==DIV/2 (integer division); otherwise 0.
    - At div_cnt==DIV-1, advance to the next bit and increment bit_cnt.
    - After bit WIDTH-1 completes, go to DONE.
  - DONE: one cycle. frame=0, d=0, enable=0, done=1, ready_out=1. A handshake in this cycle loads the next word and goes straight to SHIFT; otherwise go to IDLE.
- Latency: accept at edge k.
  - frame high and first bit on d for cycles k+1 .. k+WIDTH*DIV.
  - done high in cycle k+WIDTH*DIV+1.
  - Minimum word period is WIDTH*DIV+1 cycles. frame is always low for at least one cycle between words.
- Capture: data_in is captured only at the accepting edge. Later changes to data_in do not affect the word in flight. valid_in is ignored while ready_out=0 and no word is queued.
- Reset mid-frame: at the next edge, outputs take their reset values, the in-flight word is discarded, no done pulse is issued, and no further enable strobes occur.
- Strobe count: exactly WIDTH enable pulses per word, each inside frame. enable is never high while frame=0.
- Simultaneous reset and handshake: reset wins and the word is not accepted.

Test Plan:
1. Reset for 3 cycles, then release -> during reset d=0, enable=0, frame=0, done=0, ready_out=0. ready_out=1 one cycle after release.
2. WIDTH=8, DIV=4, MSB_FIRST=1, send 0xA5 ->
   - d = 1,0,1,0,0,1,0,1, each held 4 cycles.
   - 8 enable pulses, each at the 3rd cycle of its bit.
   - frame high for 32 cycles; done pulses 33 cycles after accept.
   - A dff driven by d/enable reconstructs 0xA5.
3. MSB_FIRST=0, send 0x01 -> d=1 for the first 4 cycles only, then 0 for 28 cycles; 8 enable pulses.
4. Back-to-back: hold valid_in high with 0x3C, then 0xC3 presented in the done cycle ->
   - second frame starts the cycle after done, with exactly one frame-low cycle between words.
   - Both words are reconstructed correctly, 16 strobes total.
5. Change data_in and toggle valid_in during SHIFT -> transmitted bits unchanged; no extra accept; ready_out stays 0 until done.
6. Assert reset at bit 3 of word 0xFF -> next cycle d=0, frame=0, enable=0. No done and no further strobes. A new word sent after release transmits fully.
